draw_intctrl: RTL and testbench
===============================

Name: draw_intctrl

Overview:
Host-facing control and interrupt stage that sits directly downstream of the draw interrupt/error generator.
- Starts and aborts a draw run by issuing the INITCMND and DRW_START pulses.
- Consumes DRW_INT, DRW_ERRINT, ERROR_REG, BUSY and WORKINGDRW and latches them into host-visible sticky status.
- Runs a watchdog on the draw run.
- Drives a single level interrupt line to the host through a simple register port.

Parameters:
TO_W, 24, width of the watchdog timeout register/counter
TO_DEFAULT, 24'h0F_FFFF, reset value of the TIMEOUT register (0 = watchdog disabled)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
REG_WE  in  1  host write strobe, one cycle per write
REG_RE  in  1  host read strobe, one cycle per read
REG_ADDR  in  3  word address
REG_WDATA  in  32  write data
REG_RDATA  out  32  read data, valid when REG_RVALID
REG_RVALID  out  1  one-cycle read-data valid
DRW_INT  in  1  end-of-display-list pulse from interrupt generator
DRW_ERRINT  in  1  one-cycle error pulse from interrupt generator
ERROR_REG  in  12  error detail vector from interrupt generator
BUSY  in  1  draw pipeline busy
WORKINGDRW  in  1  VRAM side working
INITCMND  out  1  one-cycle init pulse to draw units (active high)
DRW_START  out  1  one-cycle start pulse to display-list fetch
IRQ  out  1  level interrupt to host

Behaviour:
Reset:
- All outputs 0.
- State = IDLE; INTSTAT = 0; INTMASK = 0; ERRINFO = 0; TIMEOUT = TO_DEFAULT; counter = 0.

Register map (REG_ADDR); addresses 6 and 7 read 0 and ignore writes:
- 0 CTRL (write only, reads 0): bit0 START, bit1 ABORT; both self-clearing strobes.
- 1 STATUS (RO): [1:0] state code, [2] BUSY, [3] WORKINGDRW (sampled live).
- 2 INTSTAT (W1C): [0] DONE, [1] ERR, [2] TIMEOUT, [3] REJECT.
- 3 INTMASK (RW, [3:0]): 1 = source masked.
- 4 ERRINFO (RO, [11:0]): ERROR_REG captured at the first error of a run.
- 5 TIMEOUT (RW, [TO_W-1:0]).

Register port timing:
- Write takes effect at the clock edge where REG_WE=1.
- Read: REG_RDATA and REG_RVALID appear the cycle after REG_RE and hold for exactly one cycle.
- Read and write to the same address in the same cycle: the read returns the pre-write value.

State machine (IDLE=0, INIT=1, RUN=2, ERR=3):
- IDLE: START -> INIT, INITCMND=1 for that one cycle; ERRINFO cleared.
- INIT: always -> RUN next cycle, DRW_START=1 for that one cycle; counter cleared.
- RUN, evaluated in priority order:
  - DRW_ERRINT=1 -> ERR; INTSTAT[1] set.
  - else DRW_INT=1 -> IDLE; INTSTAT[0] set.
  - else if TIMEOUT != 0 and counter == TIMEOUT-1 -> ERR, INTSTAT[2] set, INITCMND pulse. A timeout therefore fires on the TIMEOUT-th RUN cycle.
  - otherwise counter += 1.
- ERR: -> IDLE in the cycle after INTSTAT[2:1] both read 0 (host cleared them via W1C).
- START when not IDLE: ignored, sets INTSTAT[3]; state unchanged.
- ABORT in any state: INITCMND pulse, -> IDLE, counter cleared, no INTSTAT bit set. ABORT wins over a simultaneous START.

Event and capture rules:
- DRW_INT and DRW_ERRINT in the same RUN cycle: set both bits; state -> ERR.
- DRW_INT or DRW_ERRINT outside RUN: the bit is still latched and no state change occurs.
- ERRINFO captures ERROR_REG on a DRW_ERRINT cycle only while INTSTAT[1] is 0.
- Hardware set and W1C of the same INTSTAT bit in one cycle: set wins.

Interrupt and reset:
- IRQ = OR of (INTSTAT & ~INTMASK). It is combinational from registers, so it rises the cycle after the event latches.
- RST mid-run: everything returns to reset values on the next edge. No INITCMND is issued by reset.

Decomposition:
- Shared package draw_pkg:
  - state enum {IDLE, INIT, RUN, ERR}
  - register address constants ADDR_CTRL … ADDR_TIMEOUT
  - INTSTAT bit indices INT_DONE, INT_ERR, INT_TO, INT_REJ
- One sub-module, draw_wdt: TO_W-bit counter with clear, enable and limit inputs, and an expire output.

Test Plan:
1. Write CTRL=1 in IDLE -> INITCMND high 1 cycle, DRW_START high the next cycle, STATUS[1:0]=2; pulse DRW_INT 5 cycles later -> INTSTAT=4'h1, IRQ=1, STATUS[1:0]=0; write INTSTAT=1 -> IRQ=0.
2. In RUN, drive ERROR_REG=12'h042 with DRW_ERRINT pulse, then ERROR_REG=12'h081 with a second pulse -> ERRINFO=12'h042, INTSTAT=4'h2, state ERR; write INTSTAT=2 -> IDLE.
3. TIMEOUT=4, start, no DRW_INT -> on the 4th RUN cycle INITCMND pulses, INTSTAT=4'h4, state ERR.
4. Set INTMASK=4'h1, complete a run -> INTSTAT[0]=1 and IRQ=0; clear the mask -> IRQ=1 immediately.
5. START during RUN -> INTSTAT[3]=1, state stays RUN; ABORT+START in the same write (CTRL=3) -> INITCMND pulse, state IDLE, no DRW_START.
6. DRW_INT and DRW_ERRINT in the same cycle with a concurrent W1C of bit0 -> INTSTAT=4'h3, state ERR; assert RST mid-RUN -> all outputs 0 and TIMEOUT=TO_DEFAULT next cycle.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the draw host-control/interrupt stage: state codes,
// register addresses and INTSTAT bit positions.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_INTSTAT = 3'd2;
  localparam logic [2:0] ADDR_INTMASK = 3'd3;
  localparam logic [2:0] ADDR_ERRINFO = 3'd4;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd5;

  localparam int unsigned INT_DONE = 0;
  localparam int unsigned INT_ERR  = 1;
  localparam int unsigned INT_TO   = 2;
  localparam int unsigned INT_REJ  = 3;

endpackage

// File: rtl/draw_wdt.sv
// Draw-run watchdog: counts enabled cycles and flags the cycle on which the
// count reaches LIMIT-1. LIMIT of zero disables expiry.
module draw_wdt #(
  parameter int unsigned TO_W = 24
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CLR,
  input  logic            EN,
  input  logic [TO_W-1:0] LIMIT,
  output logic            EXPIRE
);

  logic [TO_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      count <= '0;
    end else if (EN) begin
      count <= count + TO_W'(1);
    end
  end

  assign EXPIRE = (LIMIT != '0) && (count == LIMIT - TO_W'(1));

endmodule

// File: rtl/draw_intctrl.sv
// Host-facing control and interrupt stage for the draw engine: run FSM,
// sticky interrupt status, watchdog and a small register port.
module draw_intctrl
  import draw_pkg::*;
#(
  parameter int unsigned     TO_W       = 24,
  parameter logic [TO_W-1:0] TO_DEFAULT = 24'h0F_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REG_WE,
  input  logic        REG_RE,
  input  logic [2:0]  REG_ADDR,
  input  logic [31:0] REG_WDATA,
  output logic [31:0] REG_RDATA,
  output logic        REG_RVALID,
  input  logic        DRW_INT,
  input  logic        DRW_ERRINT,
  input  logic [11:0] ERROR_REG,
  input  logic        BUSY,
  input  logic        WORKINGDRW,
  output logic        INITCMND,
  output logic        DRW_START,
  output logic        IRQ
);

  state_t          state, state_nxt;
  logic [3:0]      intstat, intmask;
  logic [11:0]     errinfo;
  logic [TO_W-1:0] timeout;

  logic        wr_ctrl, start_req, abort_req;
  logic [3:0]  w1c, set_bits;
  logic        init_nxt, start_nxt, errinfo_clr;
  logic        wdt_clr, wdt_en, wdt_expire;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign wr_ctrl      = REG_WE && (REG_ADDR == ADDR_CTRL);
  assign start_req    = wr_ctrl && REG_WDATA[0];
  assign abort_req    = wr_ctrl && REG_WDATA[1];
  assign w1c          = (REG_WE && (REG_ADDR == ADDR_INTSTAT)) ? REG_WDATA[3:0] : 4'd0;
  assign unused_wdata = ^REG_WDATA;

  always_comb begin
    state_nxt            = state;
    init_nxt             = 1'b0;
    start_nxt            = 1'b0;
    errinfo_clr          = 1'b0;
    wdt_clr              = 1'b0;
    wdt_en               = 1'b0;
    set_bits             = '0;
    // Event pulses latch in every state; only RUN reacts to them.
    set_bits[INT_DONE]   = DRW_INT;
    set_bits[INT_ERR]    = DRW_ERRINT;
    if (abort_req) begin
      state_nxt = IDLE;
      init_nxt  = 1'b1;
      wdt_clr   = 1'b1;
    end else begin
      if (start_req && (state != IDLE)) set_bits[INT_REJ] = 1'b1;
      case (state)
        IDLE: begin
          if (start_req) begin
            state_nxt   = INIT;
            init_nxt    = 1'b1;
            errinfo_clr = 1'b1;
          end
        end
        INIT: begin
          state_nxt = RUN;
          start_nxt = 1'b1;
          wdt_clr   = 1'b1;
        end
        RUN: begin
          if (DRW_ERRINT) begin
            state_nxt = ERR;
          end else if (DRW_INT) begin
            state_nxt = IDLE;
          end else if (wdt_expire) begin
            state_nxt        = ERR;
            set_bits[INT_TO] = 1'b1;
            init_nxt         = 1'b1;
          end else begin
            wdt_en = 1'b1;
          end
        end
        ERR: begin
          if (!intstat[INT_ERR] && !intstat[INT_TO]) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      intstat   <= '0;
      intmask   <= '0;
      errinfo   <= '0;
      timeout   <= TO_DEFAULT;
      INITCMND  <= 1'b0;
      DRW_START <= 1'b0;
    end else begin
      state     <= state_nxt;
      INITCMND  <= init_nxt;
      DRW_START <= start_nxt;
      // Hardware set takes precedence over a same-cycle W1C.
      intstat   <= (intstat & ~w1c) | set_bits;
      if (REG_WE && (REG_ADDR == ADDR_INTMASK)) intmask <= REG_WDATA[3:0];
      if (REG_WE && (REG_ADDR == ADDR_TIMEOUT)) timeout <= REG_WDATA[TO_W-1:0];
      if (DRW_ERRINT && !intstat[INT_ERR]) begin
        errinfo <= ERROR_REG;
      end else if (errinfo_clr) begin
        errinfo <= '0;
      end
    end
  end

  draw_wdt #(
    .TO_W (TO_W)
  ) u_wdt (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (wdt_clr),
    .EN     (wdt_en),
    .LIMIT  (timeout),
    .EXPIRE (wdt_expire)
  );

  always_comb begin
    rd_mux = '0;
    case (REG_ADDR)
      ADDR_STATUS:  rd_mux = {28'd0, WORKINGDRW, BUSY, state};
      ADDR_INTSTAT: rd_mux = {28'd0, intstat};
      ADDR_INTMASK: rd_mux = {28'd0, intmask};
      ADDR_ERRINFO: rd_mux = {20'd0, errinfo};
      ADDR_TIMEOUT: rd_mux = 32'(timeout);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      REG_RVALID <= 1'b0;
      REG_RDATA  <= '0;
    end else begin
      REG_RVALID <= REG_RE;
      REG_RDATA  <= REG_RE ? rd_mux : 32'd0;
    end
  end

  assign IRQ = |(intstat & ~intmask);

endmodule

// File: tb/tb_draw_intctrl.sv
// Directed bench for draw_intctrl: register table plus hand-written run,
// error, timeout, mask, abort and reset sequences.
module tb_draw_intctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REG_WE, REG_RE;
  logic [2:0]  REG_ADDR;
  logic [31:0] REG_WDATA;
  logic [31:0] REG_RDATA;
  logic        REG_RVALID;
  logic        DRW_INT, DRW_ERRINT;
  logic [11:0] ERROR_REG;
  logic        BUSY, WORKINGDRW;
  logic        INITCMND, DRW_START, IRQ;

  int checks   = 0;
  int failures = 0;

  draw_intctrl #(
    .TO_W       (24),
    .TO_DEFAULT (24'h0F_FFFF)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REG_WE     (REG_WE),
    .REG_RE     (REG_RE),
    .REG_ADDR   (REG_ADDR),
    .REG_WDATA  (REG_WDATA),
    .REG_RDATA  (REG_RDATA),
    .REG_RVALID (REG_RVALID),
    .DRW_INT    (DRW_INT),
    .DRW_ERRINT (DRW_ERRINT),
    .ERROR_REG  (ERROR_REG),
    .BUSY       (BUSY),
    .WORKINGDRW (WORKINGDRW),
    .INITCMND   (INITCMND),
    .DRW_START  (DRW_START),
    .IRQ        (IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    REG_WE = 1'b1; REG_ADDR = a; REG_WDATA = d;
    tick();
    REG_WE = 1'b0; REG_WDATA = '0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    REG_RE = 1'b1; REG_ADDR = a;
    tick();
    REG_RE = 1'b0;
    check("rvalid", 32'(REG_RVALID), 32'd1);
    d = REG_RDATA;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(name, d, exp);
  endtask

  task automatic start_run();
    reg_write(3'd0, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; REG_WE = 0; REG_RE = 0; REG_ADDR = '0; REG_WDATA = '0;
    DRW_INT = 0; DRW_ERRINT = 0; ERROR_REG = '0; BUSY = 0; WORKINGDRW = 0;
    tick(); tick();
    check("rst_initcmnd", 32'(INITCMND), 32'd0);
    check("rst_drw_start", 32'(DRW_START), 32'd0);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_rvalid", 32'(REG_RVALID), 32'd0);
    check("rst_rdata", REG_RDATA, 32'd0);
    RST = 1'b0;
    tick();

    // Register map table
    vecs[0]  = '{1'b0, 3'd1, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'd2, 32'h0000_0000};
    vecs[2]  = '{1'b0, 3'd3, 32'h0000_0000};
    vecs[3]  = '{1'b0, 3'd4, 32'h0000_0000};
    vecs[4]  = '{1'b0, 3'd5, 32'h000F_FFFF};
    vecs[5]  = '{1'b0, 3'd0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 3'd6, 32'h0000_0000};
    vecs[7]  = '{1'b1, 3'd3, 32'hFFFF_FFF5};
    vecs[8]  = '{1'b0, 3'd3, 32'h0000_0005};
    vecs[9]  = '{1'b1, 3'd5, 32'hAB12_3456};
    vecs[10] = '{1'b0, 3'd5, 32'h0012_3456};
    vecs[11] = '{1'b1, 3'd7, 32'hFFFF_FFFF};
    vecs[12] = '{1'b0, 3'd7, 32'h0000_0000};
    vecs[13] = '{1'b1, 3'd3, 32'h0000_0000};
    vecs[14] = '{1'b1, 3'd2, 32'h0000_000F};
    vecs[15] = '{1'b0, 3'd2, 32'h0000_0000};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
      else rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
    end
    tick();
    check("rvalid_one_cycle", 32'(REG_RVALID), 32'd0);

    // Live STATUS sampling
    BUSY = 1; WORKINGDRW = 1;
    rd_chk("status_live", 3'd1, 32'h0000_000C);
    BUSY = 0; WORKINGDRW = 0;

    // Read and write of the same address returns the old value
    REG_WE = 1; REG_RE = 1; REG_ADDR = 3'd3; REG_WDATA = 32'hA;
    tick();
    REG_WE = 0; REG_RE = 0;
    check("rw_same_pre", REG_RDATA, 32'h0);
    rd_chk("rw_same_post", 3'd3, 32'hA);
    reg_write(3'd3, 32'h0);

    // 1: normal run
    reg_write(3'd0, 32'd1);
    check("t1_initcmnd", 32'(INITCMND), 32'd1);
    check("t1_no_start_yet", 32'(DRW_START), 32'd0);
    tick();
    check("t1_drw_start", 32'(DRW_START), 32'd1);
    check("t1_initcmnd_off", 32'(INITCMND), 32'd0);
    rd_chk("t1_status_run", 3'd1, 32'd2);
    check("t1_drw_start_off", 32'(DRW_START), 32'd0);
    tick(); tick(); tick();
    DRW_INT = 1; tick(); DRW_INT = 0;
    check("t1_irq", 32'(IRQ), 32'd1);
    rd_chk("t1_intstat", 3'd2, 32'h1);
    rd_chk("t1_status_idle", 3'd1, 32'd0);
    reg_write(3'd2, 32'h1);
    check("t1_irq_clr", 32'(IRQ), 32'd0);

    // 2: error capture keeps first ERROR_REG
    start_run();
    ERROR_REG = 12'h042; DRW_ERRINT = 1; tick(); DRW_ERRINT = 0;
    ERROR_REG = 12'h081; tick();
    DRW_ERRINT = 1; tick(); DRW_ERRINT = 0;
    rd_chk("t2_errinfo", 3'd4, 32'h042);
    rd_chk("t2_intstat", 3'd2, 32'h2);
    rd_chk("t2_status_err", 3'd1, 32'd3);
    check("t2_irq", 32'(IRQ), 32'd1);
    reg_write(3'd2, 32'h2);
    tick();
    rd_chk("t2_status_idle", 3'd1, 32'd0);

    // 3: watchdog fires on the 4th RUN cycle
    reg_write(3'd5, 32'd4);
    start_run();
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("t3_initcmnd_c%0d", c), 32'(INITCMND), (c == 4) ? 32'd1 : 32'd0);
    end
    rd_chk("t3_intstat", 3'd2, 32'h4);
    rd_chk("t3_status_err", 3'd1, 32'd3);
    reg_write(3'd5, 32'd0);
    reg_write(3'd2, 32'h4);
    tick();
    rd_chk("t3_status_idle", 3'd1, 32'd0);

    // 4: masked DONE
    reg_write(3'd3, 32'h1);
    start_run();
    tick();
    DRW_INT = 1; tick(); DRW_INT = 0;
    check("t4_irq_masked", 32'(IRQ), 32'd0);
    rd_chk("t4_intstat", 3'd2, 32'h1);
    reg_write(3'd3, 32'h0);
    check("t4_irq_unmasked", 32'(IRQ), 32'd1);
    reg_write(3'd2, 32'h1);

    // 5: start rejected in RUN, then abort beats start
    start_run();
    reg_write(3'd0, 32'd1);
    rd_chk("t5_status_run", 3'd1, 32'd2);
    rd_chk("t5_intstat_rej", 3'd2, 32'h8);
    reg_write(3'd0, 32'd3);
    check("t5_abort_initcmnd", 32'(INITCMND), 32'd1);
    tick();
    check("t5_no_drw_start", 32'(DRW_START), 32'd0);
    rd_chk("t5_status_idle", 3'd1, 32'd0);
    rd_chk("t5_intstat_same", 3'd2, 32'h8);
    reg_write(3'd2, 32'h8);

    // 6: simultaneous events with W1C of DONE; set wins
    start_run();
    DRW_INT = 1; DRW_ERRINT = 1; ERROR_REG = 12'h5A5;
    REG_WE = 1; REG_ADDR = 3'd2; REG_WDATA = 32'h1;
    tick();
    DRW_INT = 0; DRW_ERRINT = 0; REG_WE = 0;
    rd_chk("t6_intstat", 3'd2, 32'h3);
    rd_chk("t6_status_err", 3'd1, 32'd3);
    rd_chk("t6_errinfo", 3'd4, 32'h5A5);
    reg_write(3'd2, 32'h3);
    tick();

    // Reset in the middle of a run
    reg_write(3'd5, 32'h55);
    start_run();
    reg_write(3'd0, 32'd1);
    check("t6_pre_rst_irq", 32'(IRQ), 32'd1);
    RST = 1; REG_RE = 1; REG_ADDR = 3'd5;
    tick();
    REG_RE = 0;
    check("t6_rst_initcmnd", 32'(INITCMND), 32'd0);
    check("t6_rst_drw_start", 32'(DRW_START), 32'd0);
    check("t6_rst_irq", 32'(IRQ), 32'd0);
    check("t6_rst_rvalid", 32'(REG_RVALID), 32'd0);
    RST = 0;
    rd_chk("t6_timeout_default", 3'd5, 32'h000F_FFFF);
    rd_chk("t6_status_idle", 3'd1, 32'd0);
    rd_chk("t6_intstat_zero", 3'd2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
